shift_rate_sequencer: RTL and testbench

- Sequences a W-bit shift register at a selectable slow rate of 1, 2, 4 or 8 Hz.
- Contains an internal tick divider that runs only while a run is active, and a small FSM (IDLE / SHIFT / DONE).
- Performs a load-then-shift run on request, with a start/busy/done handshake.
- Sits between board push-buttons/switches and the LED/shift-register display path. It replaces a free-running divider with a controlled, restartable one.

---
 rtl/shift_rate_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_shift_rate_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rate_sequencer.sv
// ---------------------------------------------------------------------------
// shift_rate_sequencer
//
// Purpose:
//   Runs a W-bit shift register at a slow, selectable rate (1/2/4/8 Hz from a
//   CLK_HZ clock). A run is requested with i_start: the register is loaded
//   from i_din, then shifted once per divider period until W shifts are done
//   (logical mode) or until i_stop (rotate mode). The tick divider only runs
//   while a run is active, so every run starts with a full, clean period.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   i_start     in   level; starts a run when idle
//   i_stop      in   level; ends a run early (wins over a coincident shift)
//   i_pause     in   level; freezes divider and shifting during a run
//   i_rate_sel  in   0=1 Hz, 1=2 Hz, 2=4 Hz, 3=8 Hz (latched at start)
//   i_dir       in   1=shift toward MSB, 0=toward LSB (latched at start)
//   i_mode      in   0=logical, W shifts; 1=rotate until stop (latched)
//   i_ser_in    in   fill bit in logical mode, sampled on each shift
//   i_din       in   parallel load value, captured at start
//   o_q         out  shift register contents
//   o_sout      out  last bit shifted out
//   o_tick      out  high in the cycle a shift takes effect at the next edge
//   o_busy      out  high while shifting
//   o_done      out  one-cycle pulse when a run finishes
// ---------------------------------------------------------------------------
module shift_rate_sequencer #(
  parameter int CLK_HZ = 50000000,
  parameter int W      = 8,
  parameter int DIV_W  = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic         i_pause,
  input  logic [1:0]   i_rate_sel,
  input  logic         i_dir,
  input  logic         i_mode,
  input  logic         i_ser_in,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_q,
  output logic         o_sout,
  output logic         o_tick,
  output logic         o_busy,
  output logic         o_done
);

  localparam int CNT_W = $clog2(W + 1);

  // Terminal counts (period - 1) for each rate.
  localparam logic [DIV_W-1:0] TC_1HZ = DIV_W'(CLK_HZ - 1);
  localparam logic [DIV_W-1:0] TC_2HZ = DIV_W'((CLK_HZ >> 1) - 1);
  localparam logic [DIV_W-1:0] TC_4HZ = DIV_W'((CLK_HZ >> 2) - 1);
  localparam logic [DIV_W-1:0] TC_8HZ = DIV_W'((CLK_HZ >> 3) - 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_q;
  logic             r_sout;
  logic             r_busy;
  logic             r_done;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_rate;
  logic             r_dir;
  logic             r_mode;

  logic [DIV_W-1:0] w_tc;
  logic             w_terminal;
  logic             w_shift;
  logic             w_out_bit;
  logic             w_fill;
  logic [W-1:0]     w_q_shifted;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_last;

  always_comb begin
    w_tc = TC_1HZ;
    case (r_rate)
      2'd0:    w_tc = TC_1HZ;
      2'd1:    w_tc = TC_2HZ;
      2'd2:    w_tc = TC_4HZ;
      default: w_tc = TC_8HZ;
    endcase
  end

  assign w_terminal = (r_div == w_tc);

  // A shift happens only on terminal count with neither pause nor stop;
  // stop wins so an early end never sneaks in one extra shift.
  assign w_shift = (r_state == ST_SHIFT) && w_terminal && !i_pause && !i_stop;

  assign w_out_bit   = r_dir ? r_q[W-1] : r_q[0];
  assign w_fill      = r_mode ? w_out_bit : i_ser_in;
  assign w_q_shifted = r_dir ? {r_q[W-2:0], w_fill} : {w_fill, r_q[W-1:1]};

  // Rotate runs are unbounded, so the count saturates instead of wrapping.
  assign w_cnt_next = (r_cnt == CNT_FULL) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_last     = !r_mode && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_sout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_rate  <= 2'd0;
      r_dir   <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_q     <= i_din;
            r_rate  <= i_rate_sel;
            r_dir   <= i_dir;
            r_mode  <= i_mode;
            r_div   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (i_stop) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (!i_pause) begin
            if (w_terminal) begin
              r_div  <= '0;
              r_q    <= w_q_shifted;
              r_sout <= w_out_bit;
              r_cnt  <= w_cnt_next;
              if (w_last) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
            end else begin
              r_div <= r_div + DIV_W'(1);
            end
          end
        end

        ST_DONE: begin
          // One-cycle pulse; start is only honoured back in idle.
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_q    = r_q;
  assign o_sout = r_sout;
  assign o_busy = r_busy;
  assign o_done = r_done;
  // Combinational so the pulse lines up with the shifting cycle even when
  // pause/stop arrive in that same cycle.
  assign o_tick = w_shift;

endmodule

// File: tb/tb_shift_rate_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_rate_sequencer
//
// Directed bench for shift_rate_sequencer with CLK_HZ=16, W=8 so a 1 Hz
// period is 16 cycles. Cycle 0 is the cycle in which start is high; inputs
// change just after the falling edge and outputs are sampled 1 time unit
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_shift_rate_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       pause;
  logic [1:0] rate_sel;
  logic       dir;
  logic       mode;
  logic       ser_in;
  logic [7:0] din;
  logic [7:0] q;
  logic       sout;
  logic       tick;
  logic       busy;
  logic       done;

  int tests_run;
  int fails;
  int cyc;

  shift_rate_sequencer #(
    .CLK_HZ(16),
    .W(8),
    .DIV_W(5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (start),
    .i_stop    (stop),
    .i_pause   (pause),
    .i_rate_sel(rate_sel),
    .i_dir     (dir),
    .i_mode    (mode),
    .i_ser_in  (ser_in),
    .i_din     (din),
    .o_q       (q),
    .o_sout    (sout),
    .o_tick    (tick),
    .o_busy    (busy),
    .o_done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Drive one start cycle (cycle 0) with the given run settings.
  task automatic launch(input logic [7:0] d, input logic [1:0] r,
                        input logic dr, input logic m, input logic s);
    @(negedge clk);
    cyc      = 0;
    din      = d;
    rate_sel = r;
    dir      = dr;
    mode     = m;
    ser_in   = s;
    stop     = 1'b0;
    pause    = 1'b0;
    start    = 1'b1;
    #1;
  endtask

  task automatic idle_cycles(input int n);
    start = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    int nt;
    int nb;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (q !== 8'h00) begin fails++; $display("FAIL reset_q: got %h want %h", q, 8'h00); end
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++;
    if (done !== 1'b0 || sout !== 1'b0) begin
      fails++; $display("FAIL reset_done_sout: got done=%b sout=%b want 0 0", done, sout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nt = 0;
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (tick === 1'b1) nt++;
      if (busy !== 1'b0) nb++;
    end
    tests_run++;
    if (nt !== 0) begin fails++; $display("FAIL idle_no_tick: got %0d ticks want 0", nt); end
    tests_run++;
    if (nb !== 0 || q !== 8'h00) begin
      fails++; $display("FAIL idle_quiet: got busy_cycles=%0d q=%h want 0 00", nb, q);
    end
    $display("[TB] reset/idle done");
  endtask

  task automatic test_mode0_left;
    int nt;
    int terr;
    int done_cyc;
    int busy_fall;
    launch(8'h81, 2'd0, 1'b1, 1'b0, 1'b0);
    nt = 0; terr = 0; done_cyc = -1; busy_fall = -1;
    for (int i = 1; i <= 140; i++) begin
      @(negedge clk);
      cyc = i;
      start = 1'b0;
      #1;
      if (tick === 1'b1) begin
        nt++;
        if (i != 16 * nt) terr++;
      end
      if (i == 1) begin
        tests_run++;
        if (busy !== 1'b1) begin fails++; $display("FAIL m0_busy_rise: got %b want 1", busy); end
      end
      if (i == 17) begin
        tests_run++;
        if (q !== 8'h02 || sout !== 1'b1) begin
          fails++; $display("FAIL m0_first_shift: got q=%h sout=%b want 02 1", q, sout);
        end
      end
      if (done === 1'b1 && done_cyc < 0) done_cyc = i;
      if (busy !== 1'b1 && busy_fall < 0) busy_fall = i;
    end
    tests_run++;
    if (nt !== 8 || terr !== 0) begin
      fails++; $display("FAIL m0_ticks: got count=%0d misplaced=%0d want 8 0", nt, terr);
    end
    tests_run++;
    if (done_cyc !== 129 || busy_fall !== 129) begin
      fails++; $display("FAIL m0_done: got done=%0d busy_fall=%0d want 129 129", done_cyc, busy_fall);
    end
    tests_run++;
    if (q !== 8'h00) begin fails++; $display("FAIL m0_final_q: got %h want 00", q); end
    $display("[TB] mode0 left run done");
  endtask

  task automatic test_rate_scaling;
    int nt;
    int terr;
    int done_cyc;
    launch(8'hA5, 2'd3, 1'b0, 1'b0, 1'b1);
    nt = 0; terr = 0; done_cyc = -1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      cyc = i;
      start = 1'b0;
      if (i >= 3) rate_sel = 2'd0;
      #1;
      if (tick === 1'b1) begin
        nt++;
        if (i != 2 * nt) terr++;
      end
      if (done === 1'b1 && done_cyc < 0) done_cyc = i;
    end
    tests_run++;
    if (nt !== 8 || terr !== 0) begin
      fails++; $display("FAIL rate_ticks: got count=%0d misplaced=%0d want 8 0", nt, terr);
    end
    tests_run++;
    if (done_cyc !== 17) begin fails++; $display("FAIL rate_done: got %0d want 17", done_cyc); end
    tests_run++;
    if (q !== 8'hFF) begin fails++; $display("FAIL rate_final_q: got %h want ff", q); end
    $display("[TB] rate scaling run done");
  endtask

  task automatic test_rotate_stop;
    int nt;
    launch(8'h01, 2'd2, 1'b0, 1'b1, 1'b0);
    nt = 0;
    for (int i = 1; i <= 55; i++) begin
      @(negedge clk);
      cyc = i;
      start = 1'b0;
      stop = (i == 48);
      #1;
      if (tick === 1'b1) nt++;
      if (i == 5) begin
        tests_run++;
        if (q !== 8'h80 || sout !== 1'b1) begin
          fails++; $display("FAIL rot_q1: got q=%h sout=%b want 80 1", q, sout);
        end
      end
      if (i == 9) begin
        tests_run++;
        if (q !== 8'h40) begin fails++; $display("FAIL rot_q2: got %h want 40", q); end
      end
      if (i == 13) begin
        tests_run++;
        if (q !== 8'h20) begin fails++; $display("FAIL rot_q3: got %h want 20", q); end
      end
      if (i == 37) begin
        tests_run++;
        if (q !== 8'h80) begin fails++; $display("FAIL rot_q9: got %h want 80", q); end
      end
      if (i == 48) begin
        tests_run++;
        if (tick !== 1'b0) begin fails++; $display("FAIL rot_stop_tick: got %b want 0", tick); end
      end
      if (i == 49) begin
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h20) begin
          fails++; $display("FAIL rot_stop_done: got done=%b busy=%b q=%h want 1 0 20", done, busy, q);
        end
      end
    end
    stop = 1'b0;
    tests_run++;
    if (nt !== 11 || q !== 8'h20 || done !== 1'b0) begin
      fails++; $display("FAIL rot_after: got ticks=%0d q=%h done=%b want 11 20 0", nt, q, done);
    end
    $display("[TB] rotate/stop run done");
  endtask

  task automatic test_pause;
    int nt;
    int terr;
    int qerr;
    int done_cyc;
    logic [7:0] q_hold;
    launch(8'hF0, 2'd2, 1'b1, 1'b0, 1'b1);
    nt = 0; terr = 0; qerr = 0; done_cyc = -1; q_hold = 8'h00;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      cyc = i;
      start = 1'b0;
      pause = (i >= 10 && i <= 19);
      #1;
      if (tick === 1'b1) begin
        nt++;
        if (nt <= 2) begin
          if (i != 4 * nt) terr++;
        end else begin
          if (i != 22 + 4 * (nt - 3)) terr++;
        end
      end
      if (i == 10) begin
        q_hold = q;
        tests_run++;
        if (q !== 8'hC3) begin fails++; $display("FAIL pause_q_before: got %h want c3", q); end
      end
      if (i > 10 && i <= 19 && q !== q_hold) qerr++;
      if (done === 1'b1 && done_cyc < 0) done_cyc = i;
    end
    pause = 1'b0;
    tests_run++;
    if (nt !== 8 || terr !== 0) begin
      fails++; $display("FAIL pause_ticks: got count=%0d misplaced=%0d want 8 0", nt, terr);
    end
    tests_run++;
    if (qerr !== 0) begin fails++; $display("FAIL pause_q_hold: got %0d changes want 0", qerr); end
    tests_run++;
    if (done_cyc !== 43 || q !== 8'hFF) begin
      fails++; $display("FAIL pause_done: got done=%0d q=%h want 43 ff", done_cyc, q);
    end
    $display("[TB] pause run done");
  endtask

  task automatic test_reset_midrun;
    int nd;
    int nb;
    launch(8'h5A, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      cyc = i;
      start = 1'b0;
    end
    #1;
    tests_run++;
    if (q !== 8'hB4 || busy !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre: got q=%h busy=%b want b4 1", q, busy);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (q !== 8'h00 || busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_abort: got q=%h busy=%b want 00 0", q, busy);
    end
    nd = 0; nb = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (done !== 1'b0) nd++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (done !== 1'b0) nd++;
      if (busy !== 1'b0) nb++;
    end
    tests_run++;
    if (nd !== 0 || nb !== 0) begin
      fails++; $display("FAIL rstmid_no_done: got done_cycles=%0d busy_cycles=%0d want 0 0", nd, nb);
    end
    $display("[TB] reset mid-run done");
  endtask

  task automatic test_back_to_back;
    int done2;
    launch(8'h3C, 2'd3, 1'b1, 1'b0, 1'b0);
    done2 = -1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      cyc = i;
      start = (i <= 20);
      if (i >= 5) din = 8'hC3;
      #1;
      if (i == 3) begin
        tests_run++;
        if (q !== 8'h78) begin fails++; $display("FAIL b2b_run1_q: got %h want 78", q); end
      end
      if (i == 17) begin
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h00) begin
          fails++; $display("FAIL b2b_done1: got done=%b busy=%b q=%h want 1 0 00", done, busy, q);
        end
      end
      if (i == 18) begin
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          fails++; $display("FAIL b2b_idle: got busy=%b done=%b want 0 0", busy, done);
        end
      end
      if (i == 19) begin
        tests_run++;
        if (busy !== 1'b1 || q !== 8'hC3) begin
          fails++; $display("FAIL b2b_reload: got busy=%b q=%h want 1 c3", busy, q);
        end
      end
      if (i == 20) begin
        tests_run++;
        if (tick !== 1'b1) begin fails++; $display("FAIL b2b_tick2: got %b want 1", tick); end
      end
      if (i == 21) begin
        tests_run++;
        if (q !== 8'h86) begin fails++; $display("FAIL b2b_run2_q: got %h want 86", q); end
      end
      if (i > 18 && done === 1'b1 && done2 < 0) done2 = i;
    end
    tests_run++;
    if (done2 !== 35) begin fails++; $display("FAIL b2b_done2: got %0d want 35", done2); end
    $display("[TB] back-to-back runs done");
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    pause     = 1'b0;
    rate_sel  = 2'd0;
    dir       = 1'b0;
    mode      = 1'b0;
    ser_in    = 1'b0;
    din       = 8'h00;

    test_reset();
    idle_cycles(2);
    test_mode0_left();
    idle_cycles(3);
    test_rate_scaling();
    idle_cycles(3);
    test_rotate_stop();
    idle_cycles(3);
    test_pause();
    idle_cycles(3);
    test_reset_midrun();
    idle_cycles(3);
    test_back_to_back();
    idle_cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
